// File: rtl/morra_partita_tracker.sv
// Match (partita) tracker for the Morra Cinese judge: counts judged rounds,
// decides match end and winner, and keeps saturating session tallies.
//
// state  | meaning
// IDLE   | after reset, no match started yet
// ATTIVA | match in progress, rounds are counted
// FINE   | match decided, result and counters held until the next INIZIA
module morra_partita_tracker #(
  parameter int MIN_MANCHE = 4,
  parameter int LEAD       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INIZIA,
  input  logic [3:0] CONFIG,
  input  logic       manche_valid,
  input  logic [1:0] MANCHE,
  output logic [1:0] PARTITA,
  output logic       partita_fine,
  output logic       attiva,
  output logic [4:0] contatore_manche,
  output logic [4:0] vinte_primo,
  output logic [4:0] vinte_secondo,
  output logic [7:0] partite_primo,
  output logic [7:0] partite_secondo
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ATTIVA = 2'd1;
  localparam logic [1:0] S_FINE   = 2'd2;

  logic [1:0] state;
  logic [4:0] max_manche;
  logic       round_ok;
  logic [4:0] n_nxt;
  logic [4:0] p_nxt;
  logic [4:0] s_nxt;
  logic [1:0] result;

  // End decision is taken on the post-update counts so the result lands
  // in the same cycle as the final counter values.
  always_comb begin
    round_ok = (state == S_ATTIVA) && manche_valid && (MANCHE != 2'b00);
    n_nxt    = contatore_manche + 5'd1;
    p_nxt    = vinte_primo   + {4'd0, (MANCHE == 2'b01)};
    s_nxt    = vinte_secondo + {4'd0, (MANCHE == 2'b10)};
    result   = 2'b00;
    if ((n_nxt >= 5'(MIN_MANCHE)) && ({1'b0, p_nxt} >= ({1'b0, s_nxt} + 6'(LEAD))))
      result = 2'b01;
    else if ((n_nxt >= 5'(MIN_MANCHE)) && ({1'b0, s_nxt} >= ({1'b0, p_nxt} + 6'(LEAD))))
      result = 2'b10;
    else if (n_nxt == max_manche) begin
      if (p_nxt > s_nxt)
        result = 2'b01;
      else if (s_nxt > p_nxt)
        result = 2'b10;
      else
        result = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      max_manche       <= 5'd0;
      PARTITA          <= 2'b00;
      partita_fine     <= 1'b0;
      attiva           <= 1'b0;
      contatore_manche <= 5'd0;
      vinte_primo      <= 5'd0;
      vinte_secondo    <= 5'd0;
      partite_primo    <= 8'd0;
      partite_secondo  <= 8'd0;
    end else if (INIZIA) begin
      // Start or abort-and-restart; a coincident round is dropped.
      state            <= S_ATTIVA;
      max_manche       <= {1'b0, CONFIG} + 5'd4;
      PARTITA          <= 2'b00;
      partita_fine     <= 1'b0;
      attiva           <= 1'b1;
      contatore_manche <= 5'd0;
      vinte_primo      <= 5'd0;
      vinte_secondo    <= 5'd0;
    end else begin
      partita_fine <= 1'b0;
      if (round_ok) begin
        contatore_manche <= n_nxt;
        vinte_primo      <= p_nxt;
        vinte_secondo    <= s_nxt;
        if (result != 2'b00) begin
          state        <= S_FINE;
          PARTITA      <= result;
          partita_fine <= 1'b1;
          attiva       <= 1'b0;
          if (result == 2'b01 && partite_primo != 8'hFF)
            partite_primo <= partite_primo + 8'd1;
          if (result == 2'b10 && partite_secondo != 8'hFF)
            partite_secondo <= partite_secondo + 8'd1;
        end
      end
    end
  end

endmodule

// File: doc/morra_partita_tracker.md
# morra_partita_tracker

Downstream stage of the per-round MorraCinese judge. It consumes one round result (MANCHE) per valid strobe, keeps the round and score counters, and decides when a match (PARTITA) ends and who won it. It also keeps saturating tallies of matches won across the session.

## Interface
- MIN_MANCHE, 4: rounds that must be played before a 2-round lead can end the match.
- LEAD, 2: round-win lead that ends the match early.
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- INIZIA  input  1  single-cycle pulse that starts a new match and loads the config.
- CONFIG  input  4  sampled only when INIZIA=1; max rounds = CONFIG + 4 (range 4..19).
- manche_valid  input  1  single-cycle strobe: MANCHE carries a judged round.
- MANCHE  input  2  round result: 00 invalid move (not counted), 01 PRIMO wins, 10 SECONDO wins, 11 draw.
- PARTITA  output  2  00 match in progress or idle, 01 PRIMO, 10 SECONDO, 11 draw.
- partita_fine  output  1  one-cycle pulse when PARTITA becomes non-zero.
- attiva  output  1  high while a match is in progress.
- contatore_manche  output  5  rounds counted in the current match.
- vinte_primo, vinte_secondo  output  5 each  rounds won in the current match.
- partite_primo, partite_secondo  output  8 each  matches won since reset, saturating at 255.

## Operation
- States: IDLE, ATTIVA, FINE. Reset puts the block in IDLE.
- Reset values: every output is 0, and max_manche is 0.
- IDLE or FINE, INIZIA=1: go to ATTIVA.
  - max_manche <= CONFIG + 4, computed 5-bit so there is no overflow.
  - Clear contatore_manche, vinte_primo, vinte_secondo and PARTITA.
- ATTIVA, INIZIA=1: abort the running match and restart exactly as above. Session tallies are not changed.
- ATTIVA, manche_valid=1, INIZIA=0:
  - MANCHE=00: ignored, no counter changes.
  - MANCHE=01: vinte_primo +1.
  - MANCHE=10: vinte_secondo +1.
  - MANCHE=11: neither win counter changes.
  - For 01, 10 and 11, contatore_manche +1.
- End check uses the post-update values (n = rounds, p = PRIMO wins, s = SECONDO wins):
  - If n >= MIN_MANCHE and |p - s| >= LEAD, the leader wins.
  - Otherwise, if n == max_manche, the result is p>s → 01, s>p → 10, p==s → 11.
  - Otherwise, stay in ATTIVA.
- On end:
  - Go to FINE and load PARTITA with the result.
  - Pulse partita_fine.
  - Increment partite_primo or partite_secondo (draw: neither), saturating at 255.
- FINE:
  - PARTITA and all per-match counters hold.
  - manche_valid is ignored.
  - Leave only on INIZIA.
- IDLE: manche_valid is ignored.
- INIZIA and manche_valid in the same cycle: INIZIA wins and the round is discarded.
- Per-match counters cannot exceed 19, because the match is forced to end at max_manche.

## Timing
- All outputs are registered.
- Counters reflect a round in the cycle after its manche_valid.
- PARTITA, partita_fine and the tally updates appear in the cycle after the deciding manche_valid, alongside the final counter values.
- attiva rises the cycle after INIZIA and falls the same cycle PARTITA becomes non-zero.
- Back-to-back manche_valid every cycle is supported, with no stall and no ready signal.
- rst_n assertion mid-match clears everything immediately, independent of clk. Deassertion is synchronised externally.

## Test plan
- Early PRIMO win: reset, INIZIA with CONFIG=0 (max 4), rounds 01,01,01,11 → no end after round 3. After round 4: PARTITA=01, contatore_manche=4, partite_primo=1, one partita_fine pulse.
- Max-round draw: INIZIA with CONFIG=2 (max 6), rounds 01,10,01,10,11,11 → PARTITA=11 after round 6, both tallies unchanged.
- Invalid rounds ignored: INIZIA with CONFIG=0, rounds 00,10,00,10,10,10 → contatore_manche=4 and PARTITA=10 on the last round.
- Abort and priority: in ATTIVA after 3 rounds, assert INIZIA and manche_valid together → counters become 0, attiva stays 1, that round is not counted.
- FINE hold: after a match ends, drive 5 manche_valid strobes → no counter or PARTITA change. A following INIZIA restarts the match and clears PARTITA.
- Reset and saturation: force partite_primo to 255 via repeated matches, win again → stays 255. Pulse rst_n low mid-match → all outputs 0 asynchronously.
